// File: rtl/inst_prefetch_pkg.sv
// rtl/inst_prefetch_pkg.sv - shared types and constants for the instruction prefetch buffer
package inst_prefetch_pkg;

    localparam int INST_W  = 32;
    localparam int TAG_W   = 30;                // word address, addr[31:2]
    localparam int ENTRY_W = TAG_W + INST_W;

    typedef enum logic [1:0] {
        PF_IDLE    = 2'd0,                      // nothing outstanding
        PF_REQ     = 2'd1,                      // request outstanding, result wanted
        PF_DISCARD = 2'd2                       // request outstanding, result dropped
    } pf_state_e;

    typedef struct packed {
        logic [TAG_W-1:0]  addr;
        logic [INST_W-1:0] data;
    } pf_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - DEPTH-entry synchronous FIFO of {word address, instruction}
//   clk, rst      : clock, asynchronous active-low reset
//   push/push_entry: write an entry at the tail
//   pop           : drop the head entry
//   flush         : empty the FIFO; wins over push and pop
//   head          : head entry (valid when !empty)
//   empty/full/count: occupancy
module prefetch_fifo
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  pf_entry_t                push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output pf_entry_t                head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    pf_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // a simultaneous pop frees the slot the push lands in
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // storage is not reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/inst_prefetch.sv
// rtl/inst_prefetch.sv - sequential instruction prefetch buffer between IF and a handshaked memory
//   clk, rst        : clock, asynchronous active-low reset
//   fetch_ren       : IF requests an instruction at fetch_addr
//   fetch_addr      : requested PC, bits [1:0] ignored
//   fetch_adv       : IF consumes the word this cycle
//   fetch_valid     : fetch_data is the word at fetch_addr
//   fetch_data      : instruction word, zero when not valid
//   stall           : fetch_ren & ~fetch_valid
//   mem_req/mem_addr: registered read request, held until mem_ack
//   mem_ack/mem_rdata: one-cycle completion with data
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_ren,
    input  logic [31:0]       fetch_addr,
    input  logic              fetch_adv,
    output logic              fetch_valid,
    output logic [INST_W-1:0] fetch_data,
    output logic              stall,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    pf_state_e        state;
    pf_state_e        state_nxt;
    logic [TAG_W-1:0] pf_tag;
    logic [TAG_W-1:0] pf_tag_nxt;
    logic [TAG_W-1:0] flight_tag;
    logic             mem_req_q;

    pf_entry_t        head;
    pf_entry_t        push_entry;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CW-1:0]    fifo_count;

    logic [TAG_W-1:0] fetch_tag;
    logic [TAG_W-1:0] expected_tag;
    logic [TAG_W-1:0] issue_tag;
    logic             outstanding;
    logic             hit;
    logic             redirect;
    logic             push;
    logic             pop;
    logic             issue;
    logic             room;
    logic             byte_offset_unused;

    assign fetch_tag          = fetch_addr[31:2];
    assign byte_offset_unused = ^fetch_addr[1:0];

    assign outstanding = (state != PF_IDLE);
    assign hit         = ~fifo_empty & (head.addr == fetch_tag);

    // the address IF should ask for next if it keeps running sequentially
    always_comb begin
        expected_tag = pf_tag;
        if (!fifo_empty) begin
            expected_tag = head.addr;
        end else if (outstanding) begin
            expected_tag = flight_tag;
        end
    end

    assign redirect = fetch_ren & (fetch_tag != expected_tag);

    assign fetch_valid = hit;
    assign fetch_data  = hit ? head.data : '0;
    assign stall       = fetch_ren & ~hit;

    // a hit can never coincide with a redirect, so pop needs no flush guard
    assign pop  = hit & fetch_adv;
    assign push = (state == PF_REQ) & mem_ack & ~redirect;
    assign push_entry = '{addr: flight_tag, data: mem_rdata};

    // a redirect in IDLE issues straight to the new PC in the same cycle
    assign issue_tag = redirect ? fetch_tag : pf_tag;
    assign room      = ~fifo_full & ((fifo_count + CW'(outstanding)) < CW'(DEPTH));

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            PF_IDLE: begin
                // the flush on redirect always leaves room
                if (redirect || room) begin
                    issue     = 1'b1;
                    state_nxt = PF_REQ;
                end
            end
            PF_REQ: begin
                // an ack completes the request even when a redirect drops its data
                if (mem_ack) begin
                    state_nxt = PF_IDLE;
                end else if (redirect) begin
                    state_nxt = PF_DISCARD;
                end
            end
            PF_DISCARD: begin
                if (mem_ack) begin
                    state_nxt = PF_IDLE;
                end
            end
            default: state_nxt = PF_IDLE;
        endcase
    end

    always_comb begin
        pf_tag_nxt = pf_tag;
        if (redirect) pf_tag_nxt = fetch_tag;
        if (issue)    pf_tag_nxt = issue_tag + TAG_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PF_IDLE;
            pf_tag     <= RESET_PC[31:2];
            flight_tag <= '0;
            mem_req_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pf_tag    <= pf_tag_nxt;
            mem_req_q <= (state_nxt != PF_IDLE);
            if (issue) flight_tag <= issue_tag;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = {flight_tag, 2'b00};

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (fifo_count)
    );

endmodule
